// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP window sequencer and its scan counter.
package lbp_pkg;

    typedef enum logic [2:0] {
        IDLE, FILL, SHIFT, DRAIN, CALC, WAIT, WRITE, DONE
    } lbp_state_e;

    localparam int SIDE_W_DEF = 7;
    localparam int FIRST_IDX  = 1;
    localparam int LAST_IDX   = (1 << SIDE_W_DEF) - 2;
    localparam int FILL_N     = 9;
    localparam int SHIFT_N    = 3;

    // Last interior row/column index for an arbitrary image side.
    function automatic int last_idx(input int side_w);
        return (1 << side_w) - 2;
    endfunction

endpackage

// File: rtl/lbp_scan_counter.sv
// Centre (r, c) scan position and per-window fetch index; derives gray/lbp addresses.
module lbp_scan_counter
    import lbp_pkg::*;
#(
    parameter int SIDE_W = SIDE_W_DEF,
    parameter int AW     = 2 * SIDE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          advance,
    output logic [AW-1:0] gray_addr,
    output logic [AW-1:0] lbp_addr,
    output logic [1:0]    fetch_i,
    output logic [1:0]    fetch_j,
    output logic          fetch_last,
    output logic          row_start,
    output logic          row_last,
    output logic          last_window
);

    localparam logic [SIDE_W-1:0] FIRST = SIDE_W'(FIRST_IDX);
    localparam logic [SIDE_W-1:0] LAST  = SIDE_W'(last_idx(SIDE_W));

    logic [SIDE_W-1:0] r, c, row_a, col_a;
    logic [3:0]        k;
    logic [1:0]        i, j;

    // k counts fetches within the window; (i, j) walks the column-major 3x3 order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= FIRST;
            c <= FIRST;
            k <= '0;
            i <= '0;
            j <= '0;
        end else begin
            if (step) begin
                if (fetch_last) begin
                    k <= '0;
                    i <= '0;
                    j <= '0;
                end else begin
                    k <= k + 4'd1;
                    if (i == 2'd2) begin
                        i <= '0;
                        j <= j + 2'd1;
                    end else begin
                        i <= i + 2'd1;
                    end
                end
            end
            if (advance) begin
                if (row_last) begin
                    c <= FIRST;
                    r <= r + SIDE_W'(1);
                end else begin
                    c <= c + SIDE_W'(1);
                end
            end
        end
    end

    assign row_start   = (c == FIRST);
    assign row_last    = (c == LAST);
    assign last_window = row_last && (r == LAST);
    assign fetch_last  = (k == (row_start ? 4'(FILL_N - 1) : 4'(SHIFT_N - 1)));
    assign fetch_i     = i;
    assign fetch_j     = row_start ? j : 2'd2;

    // A shift fetch always reads the new right-hand column c+1.
    assign row_a = r - SIDE_W'(1) + SIDE_W'(i);
    assign col_a = row_start ? (c - SIDE_W'(1) + SIDE_W'(j)) : (c + SIDE_W'(1));

    assign gray_addr = {row_a, col_a};
    assign lbp_addr  = {r, c};

endmodule

// File: rtl/lbp_window_sequencer.sv
// Raster-scan sequencer: fetches each 3x3 window, runs the LBP compute, writes the result.
module lbp_window_sequencer
    import lbp_pkg::*;
#(
    parameter int SIDE_W = SIDE_W_DEF,
    parameter int AW     = 2 * SIDE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    output logic          win_load,
    output logic [1:0]    win_row,
    output logic [1:0]    win_col,
    output logic          win_shift,
    output logic          calc_start,
    input  logic          calc_done,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic          finish
);

    lbp_state_e    state;
    logic [AW-1:0] cnt_gray_addr, cnt_lbp_addr;
    logic [1:0]    fetch_i, fetch_j;
    logic          fetch_last, row_start, row_last, last_window;
    logic          advance;

    assign advance = (state == WRITE) && !last_window;

    lbp_scan_counter #(.SIDE_W(SIDE_W), .AW(AW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .step       (gray_req),
        .advance    (advance),
        .gray_addr  (cnt_gray_addr),
        .lbp_addr   (cnt_lbp_addr),
        .fetch_i    (fetch_i),
        .fetch_j    (fetch_j),
        .fetch_last (fetch_last),
        .row_start  (row_start),
        .row_last   (row_last),
        .last_window(last_window)
    );

    // Addresses read as zero whenever their strobe is low.
    assign gray_addr = gray_req  ? cnt_gray_addr : '0;
    assign lbp_addr  = lbp_valid ? cnt_lbp_addr  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gray_req   <= 1'b0;
            win_load   <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_shift  <= 1'b0;
            calc_start <= 1'b0;
            lbp_valid  <= 1'b0;
            finish     <= 1'b0;
        end else begin
            // Window load trails the read request by one cycle, carrying its (i, j).
            win_load   <= gray_req;
            win_row    <= fetch_i;
            win_col    <= fetch_j;
            win_shift  <= 1'b0;
            calc_start <= 1'b0;
            lbp_valid  <= 1'b0;
            case (state)
                IDLE: if (gray_ready) begin
                    state    <= FILL;
                    gray_req <= 1'b1;
                end
                FILL, SHIFT: if (fetch_last) begin
                    state    <= DRAIN;
                    gray_req <= 1'b0;
                end
                DRAIN: begin
                    state      <= CALC;
                    calc_start <= 1'b1;
                end
                CALC: state <= WAIT;
                WAIT: if (calc_done) begin
                    state     <= WRITE;
                    lbp_valid <= 1'b1;
                end
                WRITE: begin
                    if (last_window) begin
                        state <= DONE;
                    end else if (row_last) begin
                        state    <= FILL;
                        gray_req <= 1'b1;
                    end else begin
                        state     <= SHIFT;
                        gray_req  <= 1'b1;
                        win_shift <= 1'b1;
                    end
                end
                DONE:    finish <= 1'b1;
                default: state  <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = row_start;

endmodule

// File: tb/tb_lbp_window_sequencer.sv
// Scoreboard bench: reference model enumerates every fetch/load/write of a pass; a monitor pops and compares.
module tb_lbp_window_sequencer;

    localparam int SIDE_W = 5;
    localparam int AW     = 2 * SIDE_W;
    localparam int N      = 1 << SIDE_W;
    localparam int LASTI  = N - 2;
    localparam int TOTAL  = LASTI * LASTI;

    logic          clk = 1'b0;
    logic          reset, gray_ready, calc_done;
    logic          gray_req, win_load, win_shift, calc_start, lbp_valid, finish;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic [1:0]    win_row, win_col;

    lbp_window_sequencer #(.SIDE_W(SIDE_W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(gray_req), .gray_addr(gray_addr),
        .win_load(win_load), .win_row(win_row), .win_col(win_col), .win_shift(win_shift),
        .calc_start(calc_start), .calc_done(calc_done),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; bit shift; bit start; } req_t;
    typedef struct { int row; int col; } load_t;

    req_t  gq[$];
    load_t lq[$];
    int    wq[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int writes_seen = 0, last_req_cyc = 0, next_start_cyc = 0, fin_cyc = -1, done_cyc = -10;
    int lat_min = 1, lat_max = 1, target_idx = -1;
    bit stray_en = 0, arm_target = 0, saw_target = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic for one full pass, straight from the scan rules.
    task automatic push_pass();
        for (int r = 1; r <= LASTI; r++)
            for (int c = 1; c <= LASTI; c++) begin
                if (c == 1) begin
                    for (int k = 0; k < 9; k++) begin
                        int i = k % 3;
                        int j = k / 3;
                        gq.push_back('{(r - 1 + i) * N + (c - 1 + j), 1'b0, k == 0});
                        lq.push_back('{i, j});
                    end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        gq.push_back('{(r - 1 + i) * N + c + 1, i == 0, i == 0});
                        lq.push_back('{i, 2});
                    end
                end
                wq.push_back(r * N + c);
            end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compute datapath stand-in: done after a random latency, plus stray pulses.
    initial begin
        int cnt;
        cnt = 0;
        calc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                calc_done = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                calc_done = (cnt == 0);
                if (cnt == 0) done_cyc = cyc;
            end else if (calc_start) begin
                cnt = $urandom_range(lat_max, lat_min);
                calc_done = 1'b0;
            end else begin
                calc_done = stray_en && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor
    initial begin
        req_t  e;
        load_t l;
        int    a;
        bit    prev_req;
        prev_req = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 0;
            end else begin
                if (gray_req) begin
                    if (gq.size() == 0) chk("gray_req_unexpected", gray_addr, 64'hFFFF_FFFF);
                    else begin
                        e = gq.pop_front();
                        chk("gray_addr", gray_addr, e.addr);
                        chk("win_shift", win_shift, e.shift);
                        if (e.start) chk("phase_start_cycle", cyc, next_start_cyc);
                    end
                    last_req_cyc = cyc;
                end else if (win_shift) chk("win_shift_without_req", win_shift, 0);
                if (win_load) begin
                    chk("win_load_lag", prev_req, 1);
                    chk("win_shift_with_load", win_shift, 0);
                    if (lq.size() == 0) chk("win_load_unexpected", win_load, 0);
                    else begin
                        l = lq.pop_front();
                        chk("win_row", win_row, l.row);
                        chk("win_col", win_col, l.col);
                    end
                end else if (prev_req) chk("win_load_missing", win_load, 1);
                if (calc_start) begin
                    chk("calc_start_cycle", cyc, last_req_cyc + 2);
                    if (arm_target && writes_seen == target_idx) saw_target = 1;
                end
                if (lbp_valid) begin
                    if (wq.size() == 0) chk("lbp_valid_unexpected", lbp_addr, 64'hFFFF_FFFF);
                    else begin
                        a = wq.pop_front();
                        chk("lbp_addr", lbp_addr, a);
                        if (wq.size() == 0) fin_cyc = cyc + 2;
                    end
                    chk("write_cycle", cyc, done_cyc + 1);
                    writes_seen++;
                    next_start_cyc = cyc + 1;
                end
                chk("finish", finish, (fin_cyc >= 0 && cyc >= fin_cyc));
                prev_req = gray_req;
            end
        end
    end

    task automatic chk_quiet(input string tag);
        @(negedge clk);
        chk({tag, "_gray_req"}, gray_req, 0);
        chk({tag, "_gray_addr"}, gray_addr, 0);
        chk({tag, "_win_load"}, win_load, 0);
        chk({tag, "_win_shift"}, win_shift, 0);
        chk({tag, "_win_rc"}, {win_row, win_col}, 0);
        chk({tag, "_calc_start"}, calc_start, 0);
        chk({tag, "_lbp_valid"}, lbp_valid, 0);
        chk({tag, "_lbp_addr"}, lbp_addr, 0);
        chk({tag, "_finish"}, finish, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        gq.delete(); lq.delete(); wq.delete();
        fin_cyc = -1;
        writes_seen = 0;
        arm_target = 0;
        saw_target = 0;
        chk_quiet("reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_pass();
        @(posedge clk); #1;
        gray_ready = 1'b1;
        next_start_cyc = cyc + 1;
        @(posedge clk); #1;
        gray_ready = 1'b0;
    endtask

    task automatic wait_pass(input int budget, input bit toggle);
        int n;
        n = 0;
        while (writes_seen < TOTAL && n < budget) begin
            @(posedge clk); #1;
            if (toggle) gray_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("pass_complete", writes_seen, TOTAL);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", gq.size() + lq.size() + wq.size(), 0);
        chk("finish_held", finish, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        gray_ready = 1'b0;
        repeat (3) @(posedge clk);
        chk_quiet("init");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Pass A: fixed 1-cycle compute latency, full image.
        lat_min = 1; lat_max = 1; stray_en = 0;
        push_pass();
        start_pass();
        wait_pass(TOTAL * 10 + 1000, 0);

        // Pass B: reset while waiting on compute at centre (5,9).
        do_reset();
        lat_min = 3; lat_max = 3;
        target_idx = (5 - 1) * LASTI + (9 - 1);
        arm_target = 1;
        push_pass();
        start_pass();
        n = 0;
        while (!saw_target && n < TOTAL * 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_target_centre", saw_target, 1);
        do_reset();

        // Pass C: random latency, stray done pulses, gray_ready wandering.
        lat_min = 1; lat_max = 20; stray_en = 1;
        push_pass();
        start_pass();
        wait_pass(TOTAL * 40 + 1000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_window_sequencer.md
Name: lbp_window_sequencer

Overview:
Sequences the raster-scan LBP pass over a square gray image.
- Issues gray-memory read requests so each 3x3 neighbourhood is assembled in the downstream window register bank.
- Starts the LBP compute datapath and waits for its done handshake.
- Writes each result back with lbp_valid/lbp_addr, and raises finish after the last interior pixel.
- Sits between the testbench gray/lbp memories and the window/compute datapath.

Parameters:
SIDE_W, 7, log2 of image side; image is 2**SIDE_W x 2**SIDE_W (128x128 default).
AW, 2*SIDE_W, memory address width; address = {row, col}.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
gray_ready  in  1  gray memory loaded; sampled only in IDLE.
gray_req  out  1  gray read request; data returns on the next cycle.
gray_addr  out  AW  gray read address {row, col}.
win_load  out  1  datapath captures gray_data into window[win_row][win_col] this cycle.
win_row  out  2  window row index 0..2.
win_col  out  2  window column index 0..2.
win_shift  out  1  datapath shifts window columns left (col0<=col1, col1<=col2).
calc_start  out  1  one-cycle pulse: window complete, begin LBP compute.
calc_done  in  1  compute result ready; asserted at least 1 cycle after calc_start.
lbp_valid  out  1  one-cycle write strobe for the LBP result.
lbp_addr  out  AW  write address = current centre {r, c}.
finish  out  1  registered; high after the final write, held until reset.

Behaviour:
- Reset: state=IDLE; r=1, c=1, fetch count=0; all outputs 0 (addresses 0).
- Centres: r, c range over 1..2**SIDE_W-2 (1..126). Scan is row-major: c increments; at c=126, c wraps to 1 and r increments.
- States: IDLE, FILL, SHIFT, DRAIN, CALC, WAIT, WRITE, DONE.
- IDLE: gray_ready=1 moves to FILL next cycle. Otherwise stay in IDLE.
- FILL (used when c==1): 9 consecutive cycles with gray_req=1.
  - Fetch index k=0..8 is column-major: j=k/3, i=k%3.
  - gray_addr = {r-1+i, c-1+j}.
  - After k=8, go to DRAIN.
- SHIFT (used when c>1): 3 cycles with gray_req=1.
  - gray_addr = {r-1+i, c+1}, i=0..2.
  - win_shift=1 only in the first SHIFT cycle.
  - After i=2, go to DRAIN.
- Load timing: win_load trails each gray_req by exactly 1 cycle. win_row/win_col are the (i, j) of that request; in SHIFT, j=2.
  - win_shift and the first win_load never coincide.
- DRAIN: 1 cycle, gray_req=0, last win_load asserted. Then CALC.
- CALC: 1 cycle, calc_start=1. Then WAIT.
- WAIT: hold until calc_done=1. calc_done outside WAIT is ignored.
- WRITE: 1 cycle, lbp_valid=1, lbp_addr={r, c}.
  - If (r, c)==(126, 126): go to DONE.
  - Else advance the centre. Next state is FILL if the new c==1, otherwise SHIFT.
- DONE: finish=1 from the cycle after entry, permanently. No further gray_req or lbp_valid.
- Cycle cost: row start = 9+1+1+W+1 cycles; steady state = 3+1+1+W+1 cycles, where W = WAIT cycles (≥1).
- Widths: row/col arithmetic is SIDE_W bits unsigned. Interior centres guarantee no wrap in r±1, c±1.
- gray_ready deasserting mid-pass is ignored.
- Reset mid-pass: returns to IDLE immediately. Counters clear, finish clears, and no partial strobes are emitted.

Decomposition:
- Shared package lbp_pkg:
  - state enum (IDLE..DONE), SIDE_W default, FIRST_IDX=1, LAST_IDX=2**SIDE_W-2.
  - FILL_N=9, SHIFT_N=3.
- Sub-module lbp_scan_counter holds r, c and the fetch index. Its outputs are:
  - gray_addr,
  - lbp_addr,
  - last_window,
  - row_start flag.
- The FSM stays in the top.

Test Plan:
- Reset, gray_ready=1 at cycle 2 -> FILL addresses in order 0x0000, 0x0080, 0x0100, 0x0001, 0x0081, 0x0101, 0x0002, 0x0082, 0x0102.
  - win_load lags each by 1 cycle with matching (row, col).
- calc_done returned 3 cycles after calc_start at centre (1,1) -> exactly one lbp_valid with lbp_addr=0x0081.
  - Next phase is SHIFT: win_shift=1, then addresses 0x0003, 0x0083, 0x0103.
- Centre (1,126) write -> next phase is FILL at centre (2,1), first address 0x0080.
- Full pass with calc_done fixed at 1 cycle latency -> 15876 lbp_valid pulses, last lbp_addr=0x3F7E.
  - finish=1 the cycle after DONE entry, and no gray_req afterwards.
- Assert reset during WAIT at centre (5,9), then gray_ready=1 -> restart at FILL centre (1,1); finish=0 throughout.
- Random calc_done latency 1..20 cycles plus stray calc_done pulses outside WAIT -> lbp_addr sequence unchanged, one write per centre.
